parity_rx: RTL and testbench
============================

PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; even, minimum 4.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rxd  input  1  serial line from the upstream parity frame source, idle high, asynchronous to clk.
REQ-005 data  output  4  last received nibble.
REQ-006 dataValid  output  1  one-cycle pulse on each frame completion.
REQ-007 parityErr  output  1  parity mismatch flag of the last completed frame.
REQ-008 frameErr  output  1  stop-bit error flag of the last completed frame.
REQ-009 errCount  output  8  saturating count of frames with parityErr or frameErr set.
REQ-010 ledR, ledG, ledB  output  1 each  status LEDs, active-high.

Function
REQ-011 Frame format SHALL be: start (0), data[0]..data[3] LSB first, parity bit, stop (1), each CLKS_PER_BIT cycles long.
REQ-012 Parity SHALL be even: the frame is good when data[0]^data[1]^data[2]^data[3]^parity == 0.
REQ-013 rxd SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (rxs).
REQ-014 States: IDLE, START, DATA, PARITY, STOP, BREAK; single bit-timer counter and 2-bit bit index.
REQ-015 IDLE: rxs==0 -> START, timer cleared to 0.
REQ-016 START: at timer == CLKS_PER_BIT/2-1, sample rxs; 0 -> DATA with timer cleared; 1 -> IDLE (glitch rejected, no outputs change).
REQ-017 DATA/PARITY/STOP: sample rxs each time timer == CLKS_PER_BIT-1, then clear timer; DATA takes 4 samples into a shift register, LSB first, then -> PARITY; one sample -> STOP.
REQ-018 On the STOP sample cycle +1: data loaded from shift register, parityErr and frameErr updated, dataValid high for exactly one cycle.
REQ-019 dataValid SHALL assert for every completed frame, including errored ones.
REQ-020 parityErr and frameErr SHALL hold their value until the next frame completion.
REQ-021 frameErr SHALL be set when the stop sample is 0; FSM then -> BREAK; otherwise -> IDLE.
REQ-022 BREAK: remain until rxs==1, then -> IDLE; no start detection while in BREAK.
REQ-023 errCount SHALL increment by 1 on a completed frame with parityErr|frameErr, saturating at 255 (no wrap).
REQ-024 A new start bit SHALL be accepted on the first IDLE cycle after STOP, back-to-back frames with no idle gap between stop and start are supported.
REQ-025 ledR = parityErr|frameErr; ledG = ~(parityErr|frameErr) & frame-received-since-reset; ledB = ^data.

Reset
REQ-026 rst_n low SHALL immediately force: FSM IDLE, timer 0, synchronizer flops 1, data 0, dataValid 0, parityErr 0, frameErr 0, errCount 0, all LEDs 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no dataValid; after release, reception resumes at the next falling edge of rxs.
REQ-028 Release of rst_n SHALL take effect on the first rising clk edge after deassertion.

Verification (CLKS_PER_BIT=16)
REQ-029 Good frame data=4'b1011, parity 1, stop 1 -> data=4'hB, dataValid one pulse, parityErr=0, frameErr=0, errCount=0, ledG=1, ledB=1.
REQ-030 Frame data=4'h6 with parity 1 -> dataValid pulse, data=4'h6, parityErr=1, ledR=1, errCount=1.
REQ-031 rxd low for 5 cycles then high -> no dataValid, FSM back to IDLE, outputs unchanged.
REQ-032 Frame with stop bit 0 and rxd held low 40 more cycles -> frameErr=1, errCount+1, no new frame started until rxd returns high; next good frame then decodes correctly.
REQ-033 260 consecutive parity-error frames -> errCount reaches and stays 255.
REQ-034 rst_n pulsed low during DATA bit 2 -> all outputs 0 immediately, no dataValid; following good frame 4'h3 decodes with dataValid and no error.

Source files
------------

// File: rtl/parity_rx.sv
// Serial receiver for 4-bit even-parity frames: start, d0..d3 (LSB first), parity, stop.
// Decodes the nibble, flags parity and stop-bit errors, and keeps a saturating error count.
module parity_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [3:0] data,
    output logic       dataValid,
    output logic       parityErr,
    output logic       frameErr,
    output logic [7:0] errCount,
    output logic       ledR,
    output logic       ledG,
    output logic       ledB
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT/2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    bitIdx;
    logic [3:0]    shreg;
    logic          par;
    logic          rxMeta, rxs;
    logic          gotFrame;
    logic          newPerr, newFerr;

    // Line is idle high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= rxd;
            rxs    <= rxMeta;
        end
    end

    assign newPerr = ^{shreg, par};
    assign newFerr = ~rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            bitIdx    <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            data      <= '0;
            dataValid <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            errCount  <= '0;
            gotFrame  <= 1'b0;
        end else begin
            dataValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        timer <= '0;
                    end
                end
                START: begin
                    if (timer == HALF_M1) begin
                        timer  <= '0;
                        bitIdx <= '0;
                        state  <= rxs ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == FULL_M1) begin
                        timer  <= '0;
                        shreg  <= {rxs, shreg[3:1]};
                        bitIdx <= bitIdx + 1'b1;
                        if (bitIdx == 2'd3) state <= PARITY;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PARITY: begin
                    if (timer == FULL_M1) begin
                        timer <= '0;
                        par   <= rxs;
                        state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == FULL_M1) begin
                        timer     <= '0;
                        data      <= shreg;
                        parityErr <= newPerr;
                        frameErr  <= newFerr;
                        dataValid <= 1'b1;
                        gotFrame  <= 1'b1;
                        if ((newPerr || newFerr) && errCount != 8'hFF)
                            errCount <= errCount + 8'd1;
                        // A low stop bit means the line may be held in break; wait for it to recover.
                        state <= newFerr ? BREAK : IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ledR = parityErr | frameErr;
    assign ledG = ~(parityErr | frameErr) & gotFrame;
    assign ledB = ^data;
endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx at 16 clocks per bit; expected values are hand-computed.
module tb_parity_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [3:0] data;
    logic       dataValid, parityErr, frameErr;
    logic [7:0] errCount;
    logic       ledR, ledG, ledB;

    int errs = 0;
    int checks = 0;
    int vcnt = 0;
    int vbase;

    parity_rx #(.CLKS_PER_BIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .data(data), .dataValid(dataValid),
        .parityErr(parityErr), .frameErr(frameErr), .errCount(errCount),
        .ledR(ledR), .ledG(ledG), .ledB(ledB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dataValid) vcnt <= vcnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic pe, input logic fe,
                           input logic [7:0] ec, input logic [2:0] rgb);
        chk({tag, ".data"}, data, d);
        chk({tag, ".perr"}, parityErr, pe);
        chk({tag, ".ferr"}, frameErr, fe);
        chk({tag, ".cnt"}, errCount, ec);
        chk({tag, ".rgb"}, {ledR, ledG, ledB}, rgb);
    endtask

    initial begin
        idle(3);
        #1;
        chk_out("reset", 4'h0, 1'b0, 1'b0, 8'd0, 3'b000);
        chk("reset.vld", dataValid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // Good frame 1011, parity 1
        vbase = vcnt;
        send_frame(4'hB, 1'b1, 1'b1);
        idle(4);
        chk("good.vldcnt", vcnt - vbase, 1);
        chk_out("good", 4'hB, 1'b0, 1'b0, 8'd0, 3'b011);

        // 0110 with parity 1: odd total -> parity error
        vbase = vcnt;
        send_frame(4'h6, 1'b1, 1'b1);
        idle(4);
        chk("perr.vldcnt", vcnt - vbase, 1);
        chk_out("perr", 4'h6, 1'b1, 1'b0, 8'd1, 3'b100);

        // Short glitch on the line
        vbase = vcnt;
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(30);
        chk("glitch.vldcnt", vcnt - vbase, 0);
        chk_out("glitch", 4'h6, 1'b1, 1'b0, 8'd1, 3'b100);

        // Stop bit low, line held low afterwards
        vbase = vcnt;
        send_frame(4'h5, 1'b0, 1'b0);
        idle(40);
        chk("ferr.vldcnt", vcnt - vbase, 1);
        chk_out("ferr", 4'h5, 1'b0, 1'b1, 8'd2, 3'b100);
        rxd = 1'b1;
        idle(20);
        chk("break.vldcnt", vcnt - vbase, 1);

        vbase = vcnt;
        send_frame(4'h5, 1'b0, 1'b1);
        idle(4);
        chk("after_break.vldcnt", vcnt - vbase, 1);
        chk_out("after_break", 4'h5, 1'b0, 1'b0, 8'd2, 3'b010);

        // Reset during data bit 2
        vbase = vcnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rxd = 1'b1;
        idle(8);
        rst_n = 1'b0;
        #1;
        chk_out("midrst", 4'h0, 1'b0, 1'b0, 8'd0, 3'b000);
        chk("midrst.vld", dataValid, 1'b0);
        idle(3);
        rst_n = 1'b1;
        idle(40);
        chk("midrst.vldcnt", vcnt - vbase, 0);

        vbase = vcnt;
        send_frame(4'h3, 1'b0, 1'b1);
        idle(4);
        chk("post_rst.vldcnt", vcnt - vbase, 1);
        chk_out("post_rst", 4'h3, 1'b0, 1'b0, 8'd0, 3'b010);

        // Back-to-back parity-error frames drive the counter into saturation
        vbase = vcnt;
        for (int i = 1; i <= 260; i++) begin
            send_frame(4'h6, 1'b1, 1'b1);
            if (i == 254) chk("sat.254", errCount, 8'd254);
            if (i == 255) chk("sat.255", errCount, 8'd255);
        end
        idle(4);
        chk("sat.vldcnt", vcnt - vbase, 260);
        chk_out("sat", 4'h6, 1'b1, 1'b0, 8'd255, 3'b100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
